// File: rtl/mult_ctrl_pkg.sv
// Shared types and constants for the shift-add multiplier controller.
// Provides the controller state encoding and the default iteration sizing.
package mult_ctrl_pkg;

  localparam int WIDTH_C_DEF = 4;
  localparam int N_ITER      = 2 ** WIDTH_C_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/seq_mult_ctrl.sv
// Control FSM for the shift-add sequential multiplier: start -> load pulse
// -> one add_shift/shift command per cycle until count_check -> held done.
// Ports:
//   clk, reset (async, active-low)
//   start, result_ack         : host handshake in
//   ready, busy, done         : host status out (registered)
//   load                      : one-cycle operand load pulse (registered)
//   multiplier_lsb            : datapath multiplier bit 0
//   count_check               : iteration counter at terminal value
//   add_shift, shift          : iteration commands (Mealy on multiplier_lsb)
//   seq_error                 : sticky, counter at terminal value during LOAD
module seq_mult_ctrl
  import mult_ctrl_pkg::*;
#(
  parameter int WIDTH_C = WIDTH_C_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic ready,
  input  logic multiplier_lsb,
  input  logic count_check,
  output logic load,
  output logic add_shift,
  output logic shift,
  output logic busy,
  output logic done,
  input  logic result_ack,
  output logic seq_error
);

  if (WIDTH_C < 1) begin : g_bad_width
    $error("seq_mult_ctrl: WIDTH_C must be >= 1");
  end

  ctrl_state_t r_state;
  ctrl_state_t w_next;

  logic r_load;
  logic r_busy;
  logic r_done;
  logic r_ready;
  logic r_seq_error;
  logic w_calc;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (start) w_next = LOAD;
      LOAD: w_next = CALC;
      CALC: if (count_check) w_next = DONE;
      DONE: begin
        if (result_ack) w_next = start ? LOAD : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they are a pure
  // function of the state register with no input-to-output path.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_load      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_ready     <= 1'b1;
      r_seq_error <= 1'b0;
    end else begin
      r_state <= w_next;
      r_load  <= (w_next == LOAD);
      r_busy  <= (w_next == LOAD) || (w_next == CALC);
      r_done  <= (w_next == DONE);
      r_ready <= (w_next == IDLE) || (w_next == DONE);
      // A counter already at its terminal value before the first command
      // means datapath and counter are out of step.
      if (r_state == LOAD && count_check) r_seq_error <= 1'b1;
    end
  end

  assign w_calc    = (r_state == CALC);
  assign add_shift = w_calc & multiplier_lsb;
  assign shift     = w_calc & ~multiplier_lsb;

  assign load      = r_load;
  assign busy      = r_busy;
  assign done      = r_done;
  assign ready     = r_ready;
  assign seq_error = r_seq_error;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Self-checking bench for seq_mult_ctrl with a behavioural counter and
// multiplier shift register, plus a scoreboard of expected commands.
module tb_seq_mult_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic ready;
  logic multiplier_lsb;
  logic count_check;
  logic load;
  logic add_shift;
  logic shift;
  logic busy;
  logic done;
  logic result_ack;
  logic seq_error;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_in;
  logic [15:0] mreg;
  logic [3:0]  cnt;
  logic        force_cc;
  int          add_cnt;
  bit          exp_q[$];

  always #5 clk = ~clk;

  seq_mult_ctrl #(.WIDTH_C(4)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .ready(ready),
    .multiplier_lsb(multiplier_lsb),
    .count_check(count_check),
    .load(load),
    .add_shift(add_shift),
    .shift(shift),
    .busy(busy),
    .done(done),
    .result_ack(result_ack),
    .seq_error(seq_error)
  );

  // Sibling datapath shift register and iteration counter.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      mreg <= '0;
    end else if (load) begin
      mreg <= m_in;
    end else if (add_shift || shift) begin
      mreg <= mreg >> 1;
      cnt  <= cnt + 4'd1;
    end
  end

  assign multiplier_lsb = mreg[0];
  assign count_check    = (cnt == 4'd15) || force_cc;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Command monitor: every issued command must match the scoreboard.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      chk("cmd_exclusive", {31'd0, add_shift & shift}, 32'd0);
      if (add_shift || shift) begin
        if (exp_q.size() == 0) begin
          chk("cmd_unexpected", 32'd1, 32'd0);
        end else begin
          chk("cmd_value", {31'd0, add_shift}, {31'd0, exp_q.pop_front()});
          if (add_shift) add_cnt++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_bits(input logic [15:0] m);
    for (int i = 0; i < 16; i++) exp_q.push_back(m[i]);
    m_in    = m;
    add_cnt = 0;
  endtask

  task automatic launch(input logic [15:0] m);
    chk("ready_before_start", {31'd0, ready}, 32'd1);
    push_bits(m);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("load_pulse", {31'd0, load}, 32'd1);
    chk("busy_in_load", {31'd0, busy}, 32'd1);
  endtask

  task automatic calc_rest(input int exp_adds);
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("busy_in_calc", {28'd0, busy, load, done, ready}, 32'h8);
    end
    tick();
    chk("done_status", {28'd0, busy, load, done, ready}, 32'h3);
    chk("add_count", add_cnt, exp_adds);
  endtask

  task automatic ack_now();
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    chk("idle_after_ack", {28'd0, busy, load, done, ready}, 32'h1);
  endtask

  typedef struct {
    logic [15:0] m;
    int          adds;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{16'h0000, 0};
    vecs[1] = '{16'h0001, 1};
    vecs[2] = '{16'h8000, 1};
    vecs[3] = '{16'h1234, 5};
    vecs[4] = '{16'hFFFF, 16};
    vecs[5] = '{16'h5A5A, 8};

    reset      = 1'b0;
    start      = 1'b0;
    result_ack = 1'b0;
    force_cc   = 1'b0;
    m_in       = '0;
    add_cnt    = 0;

    repeat (3) tick();
    chk("reset_outputs",
        {25'd0, load, add_shift, shift, busy, done, seq_error, ready},
        32'h1);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_outputs",
          {25'd0, load, add_shift, shift, busy, done, seq_error, ready},
          32'h1);
    end

    foreach (vecs[k]) begin
      launch(vecs[k].m);
      calc_rest(vecs[k].adds);
      ack_now();
      tick();
    end

    // Held DONE with a stray start, then ack.
    launch(16'hA5A5);
    calc_rest(8);
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      tick();
      chk("done_held", {28'd0, busy, load, done, ready}, 32'h3);
    end
    start = 1'b0;
    ack_now();
    tick();
    chk("no_queued_start", {31'd0, load}, 32'd0);

    // Back-to-back: ack and start together in DONE.
    launch(16'h00F0);
    calc_rest(4);
    push_bits(16'hFFFF);
    result_ack = 1'b1;
    start      = 1'b1;
    tick();
    result_ack = 1'b0;
    start      = 1'b0;
    chk("b2b_load", {28'd0, busy, load, done, ready}, 32'hC);
    calc_rest(16);
    ack_now();

    // Reset in the middle of CALC.
    launch(16'hFFFF);
    repeat (7) tick();
    reset = 1'b0;
    exp_q.delete();
    #1;
    chk("midreset_outputs",
        {25'd0, load, add_shift, shift, busy, done, seq_error, ready},
        32'h1);
    tick();
    reset = 1'b1;
    tick();
    launch(16'h0F0F);
    chk("cnt_zero_at_load", {28'd0, cnt}, 32'd0);
    calc_rest(8);
    ack_now();

    // Misaligned counter during LOAD sets sticky seq_error.
    launch(16'h3333);
    force_cc = 1'b1;
    #1;
    force_cc = 1'b0;
    chk("seq_err_clear_in_load", {31'd0, seq_error}, 32'd0);
    force_cc = 1'b1;
    tick();
    force_cc = 1'b0;
    chk("seq_err_set", {31'd0, seq_error}, 32'd1);
    for (int i = 0; i < 15; i++) tick();
    tick();
    chk("seq_err_done", {30'd0, done, seq_error}, 32'h3);
    chk("add_count_err", add_cnt, 8);
    ack_now();
    launch(16'h0003);
    calc_rest(2);
    chk("seq_err_sticky", {31'd0, seq_error}, 32'd1);
    ack_now();
    reset = 1'b0;
    #1;
    chk("seq_err_cleared", {31'd0, seq_error}, 32'd0);
    tick();
    reset = 1'b1;
    tick();

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
